rf_wb_sched: RTL and testbench
==============================

Name: rf_wb_sched

Overview:
- Write-port scheduler and scoreboard for the 32x32 register file.
- Arbitrates the single RF write port between two writeback sources:
  - the fixed-latency pipe writeback (ALU/ext/pc+4);
  - the long-latency writeback (load/divide return).
- Tracks pending long-latency destinations and stalls issue on RAW/WAW hazards.
- Sits between decode/writeback stages and the RF write inputs (we, wR, wD).

Parameters:
- STARVE_MAX, 4: consecutive blocked cycles of a long writeback before it is forced through; range 1..15.
- NREG, 32: number of architectural registers; x0 is hardwired zero.
- XLEN, 32: data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- iss_valid  in  1  decode presents an instruction
- iss_rs1  in  5  source 1 index
- iss_rs2  in  5  source 2 index
- iss_rd  in  5  destination index
- iss_use_rs1  in  1  instruction reads rs1
- iss_use_rs2  in  1  instruction reads rs2
- iss_we  in  1  instruction writes rd
- iss_long  in  1  rd is returned via the long port
- iss_stall  out  1  decode must hold
- p_we  in  1  pipe writeback valid
- p_wr  in  5  pipe writeback index
- p_wd  in  32  pipe writeback data
- p_ready  out  1  pipe writeback accepted; low = WB stage holds
- l_valid  in  1  long writeback valid
- l_wr  in  5  long writeback index
- l_wd  in  32  long writeback data
- l_ready  out  1  long writeback accepted
- rf_we  out  1  RF write enable
- rf_wr  out  5  RF write index
- rf_wd  out  32  RF write data
- busy  out  32  scoreboard vector; bit 0 always 0
- err  out  1  sticky protocol error

Behaviour:
- Reset (async):
  - busy = 0, state = NORMAL, starve counter = 0, err = 0.
  - With inputs idle, all combinational outputs are 0 except p_ready = 1.
  - Reset mid-operation discards all pending long ops; upstream is reset too.
- Hazard check (combinational):
  - iss_stall = iss_valid & ( (use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]) | (iss_we & busy[rd]) | state==FORCE ).
  - No bypass: a long writeback clearing busy[r] in cycle N releases a dependent issue in cycle N+1.
- Issue accept = iss_valid & ~iss_stall. If accept & iss_long & iss_we & rd!=0, then busy[rd] is set at the next edge.
- Long handshake = l_valid & l_ready.
  - Clears busy[l_wr] at the next edge.
  - Set and clear of the same index in the same cycle: set wins. This is unreachable by the WAW rule and is asserted in the bench.
  - Handshake with busy[l_wr]==0 and l_wr!=0: write still performed, err <= 1 (sticky until rst).
- Source rules:
  - l_valid, l_wr and l_wd must stay stable until handshake.
  - p_we with p_wr==0 is a no-op: it is accepted, does not occupy the port and does not block the long source.
- Arbitration FSM, NORMAL:
  - Pipe has priority: p_ready = 1; l_ready = ~(p_we & p_wr!=0).
  - Starve counter increments, saturating, each cycle l_valid & ~l_ready.
  - Counter clears on long handshake or when l_valid = 0.
  - If blocked and counter == STARVE_MAX-1, go to FORCE at the next edge.
- Arbitration FSM, FORCE:
  - l_ready = 1, p_ready = 0, iss_stall = 1.
  - On long handshake, go to NORMAL at the next edge and clear the counter.
  - FORCE therefore lasts exactly 1 cycle.
- Write port (combinational, same cycle as grant):
  - rf_we = (pipe granted & p_wr!=0) | (long granted & l_wr!=0).
  - rf_wr and rf_wd come from the granted source; both are 0 when rf_we = 0.
  - Never two writes in one cycle.
- Index 0: never marked busy and never written. A long op to x0 issues without setting busy, and its handshake does not set err.

Decomposition:
- Shared defines.vh: state encodings SCHED_NORMAL=1'b0 and SCHED_FORCE=1'b1, STARVE_MAX default, register index width.
- Sub-module rf_scoreboard: busy vector, set/clear logic, and the three-way hazard compare.
- rf_wb_sched owns the FSM, the counter and the write mux.

Test Plan:
- Issue long to x5 with iss_rd=5, iss_long=1 → busy[5]=1 next cycle; then issue with rs1=5 → iss_stall=1 until l handshake l_wr=5; busy[5]=0 next cycle, and iss_stall drops the cycle after.
- p_we=1 (p_wr=3) and l_valid=1 (l_wr=7) together → rf_wr=3, l_ready=0; p_we high continuously with STARVE_MAX=4 → FORCE on cycle 4: rf_wr=7, rf_wd=l_wd, p_ready=0, iss_stall=1, then NORMAL.
- p_we=1 with p_wr=0 and l_valid=1 → l_ready=1, rf_wr=l_wr, counter stays 0.
- WAW: busy[9]=1, issue iss_we=1 iss_rd=9 iss_long=0 → iss_stall=1; no rs use → still stalled.
- l handshake with l_wr=12 while busy[12]=0 → rf_we=1, err=1 and stays 1.
- rst pulsed while busy=0x0000_0120 and state=FORCE → busy=0, NORMAL, err=0 immediately (async).

Source files
------------

// File: rtl/rf_wb_sched_pkg.sv
// rf_wb_sched_pkg: shared state encoding and sizing for the RF writeback scheduler
package rf_wb_sched_pkg;
    localparam int REG_AW = 5;
    localparam int STARVE_MAX_DEF = 4;
    typedef enum logic {SCHED_NORMAL = 1'b0, SCHED_FORCE = 1'b1} sched_state_e;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending long-latency destination tracking and hazard compare
module rf_scoreboard
    import rf_wb_sched_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic [REG_AW-1:0] rd,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic              use_rd,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_idx,
    input  logic              clr_en,
    input  logic [REG_AW-1:0] clr_idx,
    output logic [NREG-1:0]   busy,
    output logic              hazard,
    output logic              clr_busy
);
    logic [NREG-1:0] busy_nxt;

    // set is applied after clear so a same-index collision leaves the entry busy
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_idx] = 1'b0;
        if (set_en) busy_nxt[set_idx] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) busy <= '0;
        else busy <= busy_nxt;

    assign hazard   = (use_rs1 & busy[rs1]) | (use_rs2 & busy[rs2]) | (use_rd & busy[rd]);
    assign clr_busy = busy[clr_idx];
endmodule

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: RF write-port arbiter between pipe and long writebacks with issue scoreboard
module rf_wb_sched
    import rf_wb_sched_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int NREG       = 32,
    parameter int XLEN       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [REG_AW-1:0] iss_rs1,
    input  logic [REG_AW-1:0] iss_rs2,
    input  logic [REG_AW-1:0] iss_rd,
    input  logic              iss_use_rs1,
    input  logic              iss_use_rs2,
    input  logic              iss_we,
    input  logic              iss_long,
    output logic              iss_stall,
    input  logic              p_we,
    input  logic [REG_AW-1:0] p_wr,
    input  logic [XLEN-1:0]   p_wd,
    output logic              p_ready,
    input  logic              l_valid,
    input  logic [REG_AW-1:0] l_wr,
    input  logic [XLEN-1:0]   l_wd,
    output logic              l_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wr,
    output logic [XLEN-1:0]   rf_wd,
    output logic [NREG-1:0]   busy,
    output logic              err
);
    sched_state_e state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic p_act, l_hs, blocked, hazard, clr_busy, accept, p_wr_en, l_wr_en;

    // a pipe write to x0 never occupies the port
    assign p_act   = p_we & (p_wr != '0);
    assign p_ready = state == SCHED_NORMAL;
    assign l_ready = (state == SCHED_FORCE) | (l_valid & ~p_act);
    assign l_hs    = l_valid & l_ready;
    assign blocked = l_valid & ~l_ready;

    assign iss_stall = iss_valid & (hazard | (state == SCHED_FORCE));
    assign accept    = iss_valid & ~iss_stall;

    rf_scoreboard #(.NREG(NREG)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rs1      (iss_rs1),
        .rs2      (iss_rs2),
        .rd       (iss_rd),
        .use_rs1  (iss_use_rs1),
        .use_rs2  (iss_use_rs2),
        .use_rd   (iss_we),
        .set_en   (accept & iss_long & iss_we & (iss_rd != '0)),
        .set_idx  (iss_rd),
        .clr_en   (l_hs),
        .clr_idx  (l_wr),
        .busy     (busy),
        .hazard   (hazard),
        .clr_busy (clr_busy)
    );

    always_comb begin
        state_nxt = state == SCHED_FORCE ? (l_hs ? SCHED_NORMAL : SCHED_FORCE)
                  : ((blocked && cnt == 4'(STARVE_MAX - 1)) ? SCHED_FORCE : SCHED_NORMAL);
        cnt_nxt   = (l_hs | ~l_valid) ? 4'd0 : ((blocked && cnt != 4'hf) ? cnt + 4'd1 : cnt);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= SCHED_NORMAL;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end

    assign p_wr_en = p_ready & p_act;
    assign l_wr_en = l_hs & (l_wr != '0);
    assign rf_we   = p_wr_en | l_wr_en;
    assign rf_wr   = p_wr_en ? p_wr : (l_wr_en ? l_wr : '0);
    assign rf_wd   = p_wr_en ? p_wd : (l_wr_en ? l_wd : '0);

    // a long return to a register nobody is waiting on is a source protocol error
    always_ff @(posedge clk or posedge rst)
        if (rst) err <= 1'b0;
        else if (l_wr_en & ~clr_busy) err <= 1'b1;
endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: directed scenarios plus randomized run against a behavioural model
module tb_rf_wb_sched;
    localparam int STARVE = 4;

    logic clk, rst;
    logic iss_valid, iss_use_rs1, iss_use_rs2, iss_we, iss_long, iss_stall;
    logic [4:0] iss_rs1, iss_rs2, iss_rd;
    logic p_we, p_ready, l_valid, l_ready, rf_we, err;
    logic [4:0] p_wr, l_wr, rf_wr;
    logic [31:0] p_wd, l_wd, rf_wd, busy;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_busy;
    bit m_force, m_err;
    int m_blk;
    bit e_stall, e_pready, e_lready, e_hs, e_we;
    logic [4:0] e_wr;
    logic [31:0] e_wd;

    rf_wb_sched #(.STARVE_MAX(STARVE), .NREG(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
        .iss_use_rs1(iss_use_rs1), .iss_use_rs2(iss_use_rs2), .iss_we(iss_we), .iss_long(iss_long),
        .iss_stall(iss_stall),
        .p_we(p_we), .p_wr(p_wr), .p_wd(p_wd), .p_ready(p_ready),
        .l_valid(l_valid), .l_wr(l_wr), .l_wd(l_wd), .l_ready(l_ready),
        .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task idle;
        iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0;
        iss_use_rs1 = 0; iss_use_rs2 = 0; iss_we = 0; iss_long = 0;
        p_we = 0; p_wr = 0; p_wd = 0; l_valid = 0; l_wr = 0; l_wd = 0;
    endtask

    task issue_long(input logic [4:0] rd);
        iss_valid = 1; iss_we = 1; iss_long = 1; iss_rd = rd;
        iss_use_rs1 = 0; iss_use_rs2 = 0;
        tick();
        iss_valid = 0; iss_we = 0; iss_long = 0; iss_rd = 0;
    endtask

    task pulse_reset;
        idle();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        tick();
    endtask

    // behavioural model: grant rules and scoreboard as described by the block's rules
    task model_eval;
        bit p_act;
        p_act    = p_we && p_wr != 0;
        e_pready = !m_force;
        e_lready = m_force || (l_valid && !p_act);
        e_hs     = l_valid && e_lready;
        e_stall  = iss_valid && (m_force || (iss_use_rs1 && m_busy[iss_rs1]) ||
                   (iss_use_rs2 && m_busy[iss_rs2]) || (iss_we && m_busy[iss_rd]));
        e_we = 0; e_wr = 0; e_wd = 0;
        if (!m_force && p_act) begin e_we = 1; e_wr = p_wr; e_wd = p_wd; end
        else if (e_hs && l_wr != 0) begin e_we = 1; e_wr = l_wr; e_wd = l_wd; end
    endtask

    task model_step;
        if (e_hs && l_wr != 0 && !m_busy[l_wr]) m_err = 1;
        if (e_hs) m_busy[l_wr] = 0;
        if (iss_valid && !e_stall && iss_long && iss_we && iss_rd != 0) m_busy[iss_rd] = 1;
        if (m_force) begin
            if (e_hs) begin m_force = 0; m_blk = 0; end
        end else if (l_valid && !e_lready) begin
            m_blk++;
            if (m_blk >= STARVE) m_force = 1;
        end else m_blk = 0;
    endtask

    task test_reset;
        idle();
        rst = 1;
        #12;
        n_chk++; if (busy !== 32'h0) begin n_fail++; $display("FAIL reset_busy: got %h want 0", busy); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_chk++; if (p_ready !== 1'b1) begin n_fail++; $display("FAIL reset_p_ready: got %b want 1", p_ready); end
        n_chk++; if (l_ready !== 1'b0) begin n_fail++; $display("FAIL reset_l_ready: got %b want 0", l_ready); end
        n_chk++; if ({iss_stall, rf_we, rf_wr, rf_wd} !== '0) begin n_fail++; $display("FAIL reset_outs: got %b/%b/%h/%h want zeros", iss_stall, rf_we, rf_wr, rf_wd); end
        @(negedge clk); rst = 0;
        tick();
    endtask

    task test_long_raw;
        issue_long(5);
        n_chk++; if (busy !== 32'h20) begin n_fail++; $display("FAIL raw_busy_set: got %h want 00000020", busy); end
        iss_valid = 1; iss_use_rs1 = 1; iss_rs1 = 5; iss_we = 1; iss_rd = 2;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (iss_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall[%0d]: got %b want 1", i, iss_stall); end
            tick();
        end
        l_valid = 1; l_wr = 5; l_wd = 32'hdead_0005;
        #1;
        n_chk++; if ({l_ready, rf_we, rf_wr, rf_wd} !== {1'b1, 1'b1, 5'd5, 32'hdead_0005}) begin n_fail++; $display("FAIL raw_long_write: got %b %b %0d %h want 1 1 5 dead0005", l_ready, rf_we, rf_wr, rf_wd); end
        n_chk++; if (iss_stall !== 1'b1) begin n_fail++; $display("FAIL raw_no_bypass: got %b want 1", iss_stall); end
        tick();
        l_valid = 0;
        #1;
        n_chk++; if (busy !== 32'h0) begin n_fail++; $display("FAIL raw_busy_clr: got %h want 0", busy); end
        n_chk++; if (iss_stall !== 1'b0) begin n_fail++; $display("FAIL raw_release: got %b want 0", iss_stall); end
        tick();
        idle();
    endtask

    task test_starve;
        issue_long(7);
        p_we = 1; p_wr = 3; p_wd = 32'haaaa_0003;
        l_valid = 1; l_wr = 7; l_wd = 32'hbbbb_0007;
        iss_valid = 1; iss_use_rs1 = 1; iss_rs1 = 1;
        #1;
        for (int i = 0; i < STARVE; i++) begin
            n_chk++; if ({rf_we, rf_wr, rf_wd, l_ready, p_ready, iss_stall} !== {1'b1, 5'd3, 32'haaaa_0003, 1'b0, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL starve_pipe[%0d]: got we=%b wr=%0d wd=%h lr=%b pr=%b st=%b", i, rf_we, rf_wr, rf_wd, l_ready, p_ready, iss_stall); end
            tick();
        end
        n_chk++; if ({rf_we, rf_wr, rf_wd, l_ready, p_ready, iss_stall} !== {1'b1, 5'd7, 32'hbbbb_0007, 1'b1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL starve_force: got we=%b wr=%0d wd=%h lr=%b pr=%b st=%b want 1 7 bbbb0007 1 0 1", rf_we, rf_wr, rf_wd, l_ready, p_ready, iss_stall); end
        tick();
        l_valid = 0;
        #1;
        n_chk++; if ({p_ready, rf_wr, iss_stall, busy} !== {1'b1, 5'd3, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL starve_back_normal: got pr=%b wr=%0d st=%b busy=%h want 1 3 0 0", p_ready, rf_wr, iss_stall, busy); end
        idle();
        tick();
    endtask

    task test_p_zero;
        issue_long(6);
        p_we = 1; p_wr = 0; p_wd = 32'hffff_ffff;
        l_valid = 1; l_wr = 6; l_wd = 32'h6666_0006;
        #1;
        n_chk++; if ({l_ready, p_ready, rf_we, rf_wr, rf_wd} !== {1'b1, 1'b1, 1'b1, 5'd6, 32'h6666_0006}) begin
            n_fail++; $display("FAIL p_zero_long: got lr=%b pr=%b we=%b wr=%0d wd=%h want 1 1 1 6 66660006", l_ready, p_ready, rf_we, rf_wr, rf_wd); end
        tick();
        l_valid = 0;
        #1;
        n_chk++; if ({rf_we, rf_wr, rf_wd} !== '0) begin n_fail++; $display("FAIL p_zero_noop: got %b %0d %h want zeros", rf_we, rf_wr, rf_wd); end
        idle();
        tick();
    endtask

    task test_waw;
        issue_long(9);
        iss_valid = 1; iss_we = 1; iss_rd = 9; iss_long = 0;
        #1;
        n_chk++; if (iss_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %b want 1", iss_stall); end
        tick();
        n_chk++; if (iss_stall !== 1'b1) begin n_fail++; $display("FAIL waw_hold: got %b want 1", iss_stall); end
        iss_we = 0;
        #1;
        n_chk++; if (iss_stall !== 1'b0) begin n_fail++; $display("FAIL waw_no_write: got %b want 0", iss_stall); end
        iss_valid = 0;
        l_valid = 1; l_wr = 9; l_wd = 32'h9;
        tick();
        idle();
        n_chk++; if (busy !== 32'h0) begin n_fail++; $display("FAIL waw_busy_clr: got %h want 0", busy); end
    endtask

    task test_x0;
        iss_valid = 1; iss_we = 1; iss_long = 1; iss_rd = 0;
        #1;
        n_chk++; if (iss_stall !== 1'b0) begin n_fail++; $display("FAIL x0_issue: got %b want 0", iss_stall); end
        tick();
        idle();
        n_chk++; if (busy !== 32'h0) begin n_fail++; $display("FAIL x0_busy: got %h want 0", busy); end
        l_valid = 1; l_wr = 0; l_wd = 32'h1234;
        #1;
        n_chk++; if ({l_ready, rf_we, rf_wr, rf_wd} !== {1'b1, 1'b0, 5'd0, 32'd0}) begin n_fail++; $display("FAIL x0_write: got %b %b %0d %h want 1 0 0 0", l_ready, rf_we, rf_wr, rf_wd); end
        tick();
        idle();
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL x0_err: got %b want 0", err); end
    endtask

    task test_err;
        l_valid = 1; l_wr = 12; l_wd = 32'hc0de_000c;
        #1;
        n_chk++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd12, 32'hc0de_000c}) begin n_fail++; $display("FAIL err_write: got %b %0d %h want 1 12 c0de000c", rf_we, rf_wr, rf_wd); end
        tick();
        idle();
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
        repeat (3) tick();
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
    endtask

    task test_async_reset;
        issue_long(5);
        issue_long(8);
        n_chk++; if (busy !== 32'h0000_0120) begin n_fail++; $display("FAIL ar_busy: got %h want 00000120", busy); end
        p_we = 1; p_wr = 3; p_wd = 32'h3;
        l_valid = 1; l_wr = 5; l_wd = 32'h5;
        repeat (STARVE) tick();
        n_chk++; if (p_ready !== 1'b0) begin n_fail++; $display("FAIL ar_in_force: got p_ready %b want 0", p_ready); end
        #2;
        rst = 1;
        #1;
        n_chk++; if ({busy, err} !== 33'h0) begin n_fail++; $display("FAIL ar_clear: got busy=%h err=%b want 0 0", busy, err); end
        n_chk++; if ({p_ready, l_ready, rf_wr} !== {1'b1, 1'b0, 5'd3}) begin n_fail++; $display("FAIL ar_normal: got pr=%b lr=%b wr=%0d want 1 0 3", p_ready, l_ready, rf_wr); end
        idle();
        @(negedge clk); rst = 0;
        tick();
    endtask

    task test_random;
        bit hold;
        int q[$];
        pulse_reset();
        m_busy = 0; m_force = 0; m_err = 0; m_blk = 0;
        hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (!hold) begin
                q.delete();
                for (int r = 1; r < 32; r++) if (m_busy[r]) q.push_back(r);
                l_valid = q.size() != 0 && $urandom_range(0, 2) != 0;
                l_wr = l_valid ? 5'(q[$urandom_range(0, q.size() - 1)]) : 5'd0;
                l_wd = $urandom;
            end
            p_we = $urandom_range(0, 1) == 1; p_wr = 5'($urandom_range(0, 3)); p_wd = $urandom;
            iss_valid = $urandom_range(0, 1) == 1;
            iss_rs1 = 5'($urandom_range(0, 15)); iss_rs2 = 5'($urandom_range(0, 15)); iss_rd = 5'($urandom_range(0, 15));
            iss_use_rs1 = $urandom_range(0, 1) == 1; iss_use_rs2 = $urandom_range(0, 1) == 1;
            iss_we = $urandom_range(0, 1) == 1; iss_long = $urandom_range(0, 2) == 0;
            #1;
            model_eval();
            n_chk++; if (iss_stall !== e_stall) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b want %b", c, iss_stall, e_stall); end
            n_chk++; if ({p_ready, l_ready} !== {e_pready, e_lready}) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b%b want %b%b", c, p_ready, l_ready, e_pready, e_lready); end
            n_chk++; if ({rf_we, rf_wr, rf_wd} !== {e_we, e_wr, e_wd}) begin n_fail++; $display("FAIL rnd_write c%0d: got %b %0d %h want %b %0d %h", c, rf_we, rf_wr, rf_wd, e_we, e_wr, e_wd); end
            n_chk++; if ({busy, err} !== {m_busy, m_err}) begin n_fail++; $display("FAIL rnd_state c%0d: got %h %b want %h %b", c, busy, err, m_busy, m_err); end
            n_chk++; if (iss_valid && !e_stall && iss_long && iss_we && iss_rd != 0 && e_hs && iss_rd == l_wr) begin
                n_fail++; $display("FAIL rnd_set_clr_same c%0d: got idx %0d set and cleared, want no collision", c, iss_rd); end
            hold = l_valid && !e_hs;
            @(posedge clk);
            model_step();
            #1;
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_long_raw();
        test_starve();
        test_p_zero();
        test_waw();
        test_x0();
        test_err();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
